key_input_conditioner: RTL and testbench

- Input-side companion to the Nios II display path: conditions raw board push-buttons and switches before software reads them.
- Per channel: synchronise, debounce and normalise polarity of the raw KEY/Switch pins.
- Exposes debounced levels, one-cycle press pulses and a sticky press-capture register.
- Captured presses are readable and clearable by the Nios II over a simple Avalon-MM slave, with a maskable interrupt.

---
 rtl/key_input_conditioner.sv | 128 ++++++++++++
 tb/tb_key_input_conditioner.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_input_conditioner.sv
// key_input_conditioner: synchronise, debounce and capture board keys/switches.
// Software reads levels and sticky presses over Avalon-MM; IRQ on masked capture.
//
// Ports:
//   clock_50MHz    system clock, rising edge
//   reset_n        asynchronous active-low reset
//   keys_in[N]     raw asynchronous pins
//   level[N]       debounced level, 1 = pressed/on
//   press_pulse[N] one-cycle pulse on each debounced press
//   avs_*          Avalon-MM slave: 0 level, 1 capture (W1C), 2 mask, 3 zero
//   irq            OR of (capture & mask), registered
module key_input_conditioner #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic          clock_50MHz,
    input  logic          reset_n,
    input  logic [N-1:0]  keys_in,
    output logic [N-1:0]  level,
    output logic [N-1:0]  press_pulse,
    input  logic [1:0]    avs_address,
    input  logic          avs_read,
    input  logic          avs_write,
    input  logic [31:0]   avs_writedata,
    output logic [31:0]   avs_readdata,
    output logic          irq
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N-1:0] RELEASED = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [N-1:0] sync1;
    logic [N-1:0] sync2;
    logic [N-1:0] s;
    logic [N-1:0] level_next;
    logic [N-1:0] rise_next;
    logic [N-1:0] capture;
    logic [N-1:0] capture_next;
    logic [N-1:0] mask;
    logic [N-1:0] mask_next;
    logic [N-1:0] wr_clr;
    logic [31:0]  rd_mux;
    logic         unused_wdata;

    assign unused_wdata = ^avs_writedata;

    // Synchronisers start at the released pin level so reset never
    // looks like a press.
    always_ff @(posedge clock_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RELEASED;
            sync2 <= RELEASED;
        end else begin
            sync1 <= keys_in;
            sync2 <= sync1;
        end
    end

    assign s = sync2 ^ RELEASED;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [CW-1:0] cnt_q;
        logic          differs;
        logic          done;

        assign differs = s[i] != level[i];
        assign done    = differs && (cnt_q == CNT_LAST);
        assign level_next[i] = done ? s[i] : level[i];

        always_ff @(posedge clock_50MHz or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else if (!differs || done) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign rise_next = level_next & ~level;

    // A set from a fresh press beats a same-cycle clear.
    always_comb begin
        wr_clr    = '0;
        mask_next = mask;
        if (avs_write && avs_address == 2'd1) begin
            wr_clr = avs_writedata[N-1:0];
        end
        if (avs_write && avs_address == 2'd2) begin
            mask_next = avs_writedata[N-1:0];
        end
        capture_next = (capture & ~wr_clr) | rise_next;
    end

    always_comb begin
        rd_mux = '0;
        unique case (avs_address)
            2'd0: rd_mux = 32'(level);
            2'd1: rd_mux = 32'(capture);
            2'd2: rd_mux = 32'(mask);
            2'd3: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            level        <= '0;
            press_pulse  <= '0;
            capture      <= '0;
            mask         <= '0;
            avs_readdata <= '0;
            irq          <= 1'b0;
        end else begin
            level       <= level_next;
            press_pulse <= rise_next;
            capture     <= capture_next;
            mask        <= mask_next;
            irq         <= |(capture & mask);
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_key_input_conditioner.sv
// tb_key_input_conditioner: scenario tasks for key_input_conditioner.
// Bus reads push expected data to a queue; tests pop and compare inline.
module tb_key_input_conditioner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  keys_in;
    logic [3:0]  level;
    logic [3:0]  press_pulse;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] want;

    key_input_conditioner #(
        .N(4),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW(1)
    ) dut (
        .clock_50MHz(clk),
        .reset_n(reset_n),
        .keys_in(keys_in),
        .level(level),
        .press_pulse(press_pulse),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d", total);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        keys_in = 4'hF;
        avs_address = 2'd0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        #3;
        total++;
        if ({level, press_pulse, irq} !== 9'd0 || avs_readdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_vals got=%h/%h/%b/%h want=0/0/0/0",
                     level, press_pulse, irq, avs_readdata);
        end
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if (press_pulse !== 4'h0 || level !== 4'h0) begin
                bad++;
                $display("FAIL reset_quiet cyc=%0d got=%h/%h want=0/0",
                         k, level, press_pulse);
            end
        end
        rd(2'd1, 32'h0);
        want = exp_q.pop_front();
        total++;
        if (avs_readdata !== want) begin
            bad++;
            $display("FAIL reset_capture got=%h want=%h", avs_readdata, want);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq got=%b want=0", irq);
        end
    endtask

    task automatic test_press();
        keys_in = 4'hE;
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++;
            if (level !== 4'h0) begin
                bad++;
                $display("FAIL press_early edge=%0d got=%h want=0", k, level);
            end
        end
        tick();
        total++;
        if (level !== 4'h1 || press_pulse !== 4'h1) begin
            bad++;
            $display("FAIL press_edge6 got=%h/%h want=1/1", level, press_pulse);
        end
        tick();
        total++;
        if (level !== 4'h1 || press_pulse !== 4'h0) begin
            bad++;
            $display("FAIL press_pulse_len got=%h/%h want=1/0",
                     level, press_pulse);
        end
        rd(2'd1, 32'h1);
        want = exp_q.pop_front();
        total++;
        if (avs_readdata !== want) begin
            bad++;
            $display("FAIL press_capture got=%h want=%h", avs_readdata, want);
        end
        keys_in = 4'hF;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if (press_pulse !== 4'h0) begin
                bad++;
                $display("FAIL release_pulse cyc=%0d got=%h want=0",
                         k, press_pulse);
            end
        end
        total++;
        if (level !== 4'h0) begin
            bad++;
            $display("FAIL release_level got=%h want=0", level);
        end
        wr(2'd1, 32'h1);
        rd(2'd1, 32'h0);
        want = exp_q.pop_front();
        total++;
        if (avs_readdata !== want) begin
            bad++;
            $display("FAIL press_clear got=%h want=%h", avs_readdata, want);
        end
    endtask

    task automatic test_glitch();
        keys_in = 4'hD;
        tick();
        tick();
        tick();
        keys_in = 4'hF;
        for (int k = 0; k < 12; k++) begin
            tick();
            total++;
            if (level !== 4'h0 || press_pulse !== 4'h0 || irq !== 1'b0) begin
                bad++;
                $display("FAIL glitch cyc=%0d got=%h/%h/%b want=0/0/0",
                         k, level, press_pulse, irq);
            end
        end
        rd(2'd1, 32'h0);
        want = exp_q.pop_front();
        total++;
        if (avs_readdata !== want) begin
            bad++;
            $display("FAIL glitch_capture got=%h want=%h", avs_readdata, want);
        end
    endtask

    task automatic test_irq();
        wr(2'd2, 32'h1);
        rd(2'd2, 32'h1);
        want = exp_q.pop_front();
        total++;
        if (avs_readdata !== want) begin
            bad++;
            $display("FAIL mask_read got=%h want=%h", avs_readdata, want);
        end
        keys_in = 4'hE;
        for (int k = 0; k < 6; k++) tick();
        total++;
        if (press_pulse !== 4'h1 || irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_pre got=%h/%b want=1/0", press_pulse, irq);
        end
        tick();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_assert got=%b want=1", irq);
        end
        wr(2'd1, 32'h1);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_hold got=%b want=1", irq);
        end
        tick();
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_clear got=%b want=0", irq);
        end
        rd(2'd1, 32'h0);
        want = exp_q.pop_front();
        total++;
        if (avs_readdata !== want) begin
            bad++;
            $display("FAIL irq_capture got=%h want=%h", avs_readdata, want);
        end
        keys_in = 4'hF;
        for (int k = 0; k < 10; k++) tick();
    endtask

    task automatic test_same_cycle();
        keys_in = 4'hB;
        for (int k = 0; k < 5; k++) tick();
        avs_address   = 2'd1;
        avs_writedata = 32'h4;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
        total++;
        if (press_pulse !== 4'h4) begin
            bad++;
            $display("FAIL same_pulse got=%h want=4", press_pulse);
        end
        rd(2'd1, 32'h4);
        want = exp_q.pop_front();
        total++;
        if (avs_readdata !== want) begin
            bad++;
            $display("FAIL set_wins got=%h want=%h", avs_readdata, want);
        end
        wr(2'd1, 32'h4);
        keys_in = 4'hF;
        for (int k = 0; k < 10; k++) tick();
    endtask

    task automatic test_rw_same();
        exp_q.push_back(32'h1);
        avs_address   = 2'd2;
        avs_writedata = 32'hFFFF_FFFF;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        tick();
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        want = exp_q.pop_front();
        total++;
        if (avs_readdata !== want) begin
            bad++;
            $display("FAIL rw_pre got=%h want=%h", avs_readdata, want);
        end
        rd(2'd2, 32'hF);
        want = exp_q.pop_front();
        total++;
        if (avs_readdata !== want) begin
            bad++;
            $display("FAIL mask_upper got=%h want=%h", avs_readdata, want);
        end
        tick();
        total++;
        if (avs_readdata !== 32'hF) begin
            bad++;
            $display("FAIL rd_hold got=%h want=0000000f", avs_readdata);
        end
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, 32'h0);
        want = exp_q.pop_front();
        total++;
        if (avs_readdata !== want) begin
            bad++;
            $display("FAIL level_ro got=%h want=%h", avs_readdata, want);
        end
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, 32'h0);
        want = exp_q.pop_front();
        total++;
        if (avs_readdata !== want) begin
            bad++;
            $display("FAIL addr3 got=%h want=%h", avs_readdata, want);
        end
        wr(2'd2, 32'h0);
    endtask

    task automatic test_reset_mid();
        keys_in = 4'hD;
        for (int k = 0; k < 8; k++) tick();
        total++;
        if (level !== 4'h2) begin
            bad++;
            $display("FAIL mid_pre got=%h want=2", level);
        end
        keys_in = 4'h5;
        for (int k = 0; k < 4; k++) tick();
        reset_n = 1'b0;
        #1;
        total++;
        if (level !== 4'h0 || press_pulse !== 4'h0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got=%h/%h/%b want=0/0/0",
                     level, press_pulse, irq);
        end
        #2;
        reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++;
            if (level !== 4'h0) begin
                bad++;
                $display("FAIL mid_early edge=%0d got=%h want=0", k, level);
            end
        end
        tick();
        total++;
        if (level !== 4'hA || press_pulse !== 4'hA) begin
            bad++;
            $display("FAIL mid_edge6 got=%h/%h want=a/a", level, press_pulse);
        end
        tick();
        total++;
        if (press_pulse !== 4'h0) begin
            bad++;
            $display("FAIL mid_pulse_len got=%h want=0", press_pulse);
        end
        rd(2'd1, 32'hA);
        want = exp_q.pop_front();
        total++;
        if (avs_readdata !== want) begin
            bad++;
            $display("FAIL mid_capture got=%h want=%h", avs_readdata, want);
        end
        keys_in = 4'hF;
        tick();
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_irq();
        test_same_cycle();
        test_rw_same();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
